// File: rtl/icache_refill_module_pkg.sv
// Shared cache definitions for the icache refill path: widths, address
// field positions, refill FSM encoding and a line-address helper.
package icache_refill_module_pkg;

    localparam int PHY_ADDR_WIDTH    = 34;
    localparam int ICACHE_TAG_WIDTH  = 20;
    localparam int ICACHE_IDX_WIDTH  = 8;
    localparam int ICACHE_DATA_WIDTH = 512;
    localparam int LINE_WIDTH        = ICACHE_DATA_WIDTH;
    localparam int BUS_WIDTH         = 64;
    localparam int BEATS             = LINE_WIDTH / BUS_WIDTH;
    localparam int CNT_WIDTH         = $clog2(BEATS);

    localparam int OFFSET_WIDTH = 6;
    localparam int IDX_LSB      = 6;
    localparam int IDX_MSB      = 13;
    localparam int TAG_LSB      = 14;
    localparam int TAG_MSB      = 33;
    localparam int LADDR_WIDTH  = PHY_ADDR_WIDTH - OFFSET_WIDTH;

    typedef logic [LADDR_WIDTH-1:0] laddr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_WRITE = 2'd3
    } refill_state_e;

    function automatic laddr_t line_addr(input logic [PHY_ADDR_WIDTH-1:0] paddr);
        return paddr[PHY_ADDR_WIDTH-1:OFFSET_WIDTH];
    endfunction

endpackage

// File: rtl/icache_refill_module_if.sv
// Bundle of the miss, invalidation, memory and array-write signals of the
// refill block; master is the refill block, slave is its environment.
interface icache_refill_module_if;
    import icache_refill_module_pkg::*;

    logic                         i_miss_vld;
    logic [PHY_ADDR_WIDTH-1:0]    i_miss_paddr;
    logic                         o_miss_rdy;
    logic                         i_flush;
    logic                         i_icache_inv_vld;
    logic [PHY_ADDR_WIDTH-1:0]    i_icache_inv_paddr;
    logic                         o_mem_req_vld;
    logic [PHY_ADDR_WIDTH-1:0]    o_mem_req_paddr;
    logic                         i_mem_req_rdy;
    logic                         i_mem_rsp_vld;
    logic [BUS_WIDTH-1:0]         i_mem_rsp_dat;
    logic                         o_icache_wren;
    logic [ICACHE_IDX_WIDTH-1:0]  o_icache_widx;
    logic [ICACHE_TAG_WIDTH-1:0]  o_icache_wtag;
    logic [LINE_WIDTH-1:0]        o_icache_wdat;
    logic                         o_refill_busy;
    logic                         o_refill_done;

    modport master (
        input  i_miss_vld, i_miss_paddr, i_flush, i_icache_inv_vld, i_icache_inv_paddr,
        input  i_mem_req_rdy, i_mem_rsp_vld, i_mem_rsp_dat,
        output o_miss_rdy, o_mem_req_vld, o_mem_req_paddr,
        output o_icache_wren, o_icache_widx, o_icache_wtag, o_icache_wdat,
        output o_refill_busy, o_refill_done
    );

    modport slave (
        output i_miss_vld, i_miss_paddr, i_flush, i_icache_inv_vld, i_icache_inv_paddr,
        output i_mem_req_rdy, i_mem_rsp_vld, i_mem_rsp_dat,
        input  o_miss_rdy, o_mem_req_vld, o_mem_req_paddr,
        input  o_icache_wren, o_icache_widx, o_icache_wtag, o_icache_wdat,
        input  o_refill_busy, o_refill_done
    );

endinterface

// File: rtl/icache_refill_module.sv
// Single-outstanding icache miss handler: line-aligned memory read, beat
// assembly, one-cycle array write; flush or same-line invalidation kills it.
module icache_refill_module
    import icache_refill_module_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    icache_refill_module_if.master bus
);

    refill_state_e          state_q, state_d;
    laddr_t                 line_q, line_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   kill_q, kill_d;
    logic [LINE_WIDTH-1:0]  buf_q;

    logic inv_match_s;
    logic miss_rdy_s;
    logic req_vld_s;
    logic wren_s;
    logic done_s;

    assign inv_match_s = bus.i_icache_inv_vld &&
                         (line_addr(bus.i_icache_inv_paddr) == line_q);

    // Next-state, kill tracking and output decode of the refill FSM
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        kill_d     = kill_q;
        miss_rdy_s = 1'b0;
        req_vld_s  = 1'b0;
        wren_s     = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miss_rdy_s = 1'b1;
                cnt_d      = '0;
                kill_d     = 1'b0;
                if (bus.i_miss_vld && !bus.i_flush) begin
                    line_d  = line_addr(bus.i_miss_paddr);
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                req_vld_s = 1'b1;
                // Once the read is accepted the beats must be drained even if killed
                if (bus.i_mem_req_rdy) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    kill_d  = kill_q | bus.i_flush | inv_match_s;
                end else if (bus.i_flush) begin
                    state_d = ST_IDLE;
                    done_s  = 1'b1;
                    kill_d  = 1'b0;
                end else if (inv_match_s) begin
                    kill_d  = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_FILL: begin
                if (bus.i_flush || inv_match_s) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
                if (bus.i_mem_rsp_vld) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'(BEATS - 1)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WRITE: begin
                wren_s  = !kill_q && !bus.i_flush && !inv_match_s;
                done_s  = 1'b1;
                kill_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                kill_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
        end
    end

    // Latched line address; not reset
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    // Line buffer: each beat lands at its ascending-address slot
    always_ff @(posedge clk) begin
        if (state_q == ST_FILL && bus.i_mem_rsp_vld) begin
            buf_q[int'(cnt_q) * BUS_WIDTH +: BUS_WIDTH] <= bus.i_mem_rsp_dat;
        end
    end

    // While rst_n is low the outputs already show the idle values
    assign bus.o_miss_rdy      = !rst_n || miss_rdy_s;
    assign bus.o_mem_req_vld   = rst_n && req_vld_s;
    assign bus.o_icache_wren   = rst_n && wren_s;
    assign bus.o_refill_done   = rst_n && done_s;
    assign bus.o_refill_busy   = rst_n && (state_q != ST_IDLE);
    assign bus.o_mem_req_paddr = {line_q, 6'b000000};
    assign bus.o_icache_widx   = line_q[IDX_MSB-OFFSET_WIDTH:IDX_LSB-OFFSET_WIDTH];
    assign bus.o_icache_wtag   = line_q[TAG_MSB-OFFSET_WIDTH:TAG_LSB-OFFSET_WIDTH];
    assign bus.o_icache_wdat   = buf_q;

endmodule

// File: tb/tb_icache_refill_module.sv
// Directed plus randomized bench for icache_refill_module; expected values
// come from a transaction-level model of a refill.
module tb_icache_refill_module;
    import icache_refill_module_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    icache_refill_module_if bus ();

    icache_refill_module dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_WIDTH-1:0] obs,
                       input logic [LINE_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_miss_vld         = 1'b0;
        bus.i_miss_paddr       = '0;
        bus.i_flush            = 1'b0;
        bus.i_icache_inv_vld   = 1'b0;
        bus.i_icache_inv_paddr = '0;
        bus.i_mem_req_rdy      = 1'b0;
        bus.i_mem_rsp_vld      = 1'b0;
        bus.i_mem_rsp_dat      = '0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},   bus.o_refill_busy, 1'b0);
        chk({tag, "_rdy"},    bus.o_miss_rdy,    1'b1);
        chk({tag, "_reqvld"}, bus.o_mem_req_vld, 1'b0);
        chk({tag, "_wren"},   bus.o_icache_wren, 1'b0);
        chk({tag, "_done"},   bus.o_refill_done, 1'b0);
    endtask

    // One whole refill; flush_beat/inv_beat >= BEATS means "no event"
    task automatic refill(input logic [33:0] pa, input int req_wait,
                          input int flush_beat, input int inv_beat,
                          input logic [33:0] inv_pa, input bit gaps,
                          input bit seq_beats);
        logic [LINE_WIDTH-1:0] exp_line;
        logic [63:0]           beat;
        logic                  exp_wren;
        int                    g;
        exp_line = '0;
        exp_wren = 1'b1;
        if (flush_beat < BEATS) exp_wren = 1'b0;
        if (inv_beat < BEATS && inv_pa[33:6] == pa[33:6]) exp_wren = 1'b0;

        bus.i_miss_vld   = 1'b1;
        bus.i_miss_paddr = pa;
        @(negedge clk);
        chk("accept_rdy", bus.o_miss_rdy, 1'b1);
        chk("accept_busy", bus.o_refill_busy, 1'b0);
        tick();
        bus.i_miss_vld   = 1'b0;
        bus.i_miss_paddr = {$urandom(), 2'b00};

        for (int w = 0; w <= req_wait; w++) begin
            bus.i_mem_req_rdy = (w == req_wait);
            @(negedge clk);
            chk("req_vld", bus.o_mem_req_vld, 1'b1);
            chk("req_paddr", bus.o_mem_req_paddr, {pa[33:6], 6'b000000});
            chk("req_miss_rdy", bus.o_miss_rdy, 1'b0);
            chk("req_busy", bus.o_refill_busy, 1'b1);
            tick();
        end
        bus.i_mem_req_rdy = 1'b0;

        for (int b = 0; b < BEATS; b++) begin
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                @(negedge clk);
                chk("gap_wren", bus.o_icache_wren, 1'b0);
                chk("gap_reqvld", bus.o_mem_req_vld, 1'b0);
                tick();
            end
            beat = seq_beats ? 64'(b) : {$urandom(), $urandom()};
            exp_line[b*BUS_WIDTH +: BUS_WIDTH] = beat;
            bus.i_mem_rsp_vld      = 1'b1;
            bus.i_mem_rsp_dat      = beat;
            bus.i_flush            = (b == flush_beat);
            bus.i_icache_inv_vld   = (b == inv_beat);
            bus.i_icache_inv_paddr = inv_pa;
            @(negedge clk);
            chk("fill_wren", bus.o_icache_wren, 1'b0);
            chk("fill_done", bus.o_refill_done, 1'b0);
            chk("fill_busy", bus.o_refill_busy, 1'b1);
            tick();
            bus.i_mem_rsp_vld    = 1'b0;
            bus.i_flush          = 1'b0;
            bus.i_icache_inv_vld = 1'b0;
        end

        @(negedge clk);
        chk("write_done", bus.o_refill_done, 1'b1);
        chk("write_wren", bus.o_icache_wren, exp_wren);
        chk("write_widx", bus.o_icache_widx, pa[13:6]);
        chk("write_wtag", bus.o_icache_wtag, pa[33:14]);
        chk("write_wdat", bus.o_icache_wdat, exp_line);
        tick();
        @(negedge clk);
        chk_idle("after_write");
        tick();
    endtask

    initial begin
        logic [33:0] pa;
        logic [33:0] ipa;
        checks = 0;
        errors = 0;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk_idle("in_reset");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");
        tick();

        // Plain refill, zero-wait memory, back-to-back beats 0..7
        refill(34'h012345678, 0, BEATS, BEATS, '0, 1'b0, 1'b1);
        // Memory request stalled five cycles
        refill(34'h0ABCDE123, 5, BEATS, BEATS, '0, 1'b0, 1'b0);
        // Flush after beat 3: beats still drained, no write
        refill(34'h012345678, 0, 3, BEATS, '0, 1'b0, 1'b0);
        // Same-line invalidation kills, different-index invalidation does not
        refill(34'h012345610, 1, BEATS, 2, 34'h012345600, 1'b0, 1'b0);
        refill(34'h012345610, 1, BEATS, 2, 34'h012345A00, 1'b0, 1'b0);

        // Reset mid-FILL, then stray beats in IDLE
        bus.i_miss_vld   = 1'b1;
        bus.i_miss_paddr = 34'h0000FF040;
        tick();
        bus.i_miss_vld    = 1'b0;
        bus.i_mem_req_rdy = 1'b1;
        tick();
        bus.i_mem_req_rdy = 1'b0;
        bus.i_mem_rsp_vld = 1'b1;
        repeat (3) tick();
        bus.i_mem_rsp_vld = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("mid_fill_reset");
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.i_mem_rsp_vld = 1'b1;
            bus.i_mem_rsp_dat = {$urandom(), $urandom()};
            @(negedge clk);
            chk_idle("stray_beat");
            tick();
        end
        bus.i_mem_rsp_vld = 1'b0;
        refill(34'h1DEADBEEF, 0, BEATS, BEATS, '0, 1'b1, 1'b0);

        // Flush in REQ without handshake
        bus.i_miss_vld   = 1'b1;
        bus.i_miss_paddr = 34'h022222222;
        tick();
        bus.i_miss_vld = 1'b0;
        bus.i_flush    = 1'b1;
        @(negedge clk);
        chk("reqflush_vld", bus.o_mem_req_vld, 1'b1);
        chk("reqflush_done", bus.o_refill_done, 1'b1);
        chk("reqflush_wren", bus.o_icache_wren, 1'b0);
        tick();
        bus.i_flush = 1'b0;
        @(negedge clk);
        chk_idle("after_reqflush");
        tick();
        // Miss together with flush is refused
        bus.i_miss_vld   = 1'b1;
        bus.i_miss_paddr = 34'h033333333;
        bus.i_flush      = 1'b1;
        tick();
        idle_inputs();
        @(negedge clk);
        chk_idle("miss_with_flush");
        tick();
        refill(34'h033333333, 2, BEATS, BEATS, '0, 1'b0, 1'b0);

        // Randomized refills against the transaction model
        for (int n = 0; n < 24; n++) begin
            pa  = {$urandom(), 2'($urandom_range(0, 3))};
            ipa = ($urandom_range(0, 1) == 1) ? {pa[33:6], 6'($urandom())}
                                              : {$urandom(), 2'($urandom_range(0, 3))};
            refill(pa, $urandom_range(0, 3), $urandom_range(0, 15),
                   $urandom_range(0, 15), ipa, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
